// File: rtl/sprite_mover.sv
// Tile-maze sprite mover: steps one pixel every STEP_DIV cycles, probes the four
// neighbour tiles from an external wall map whenever it sits on a tile boundary,
// and turns, continues or stops based on the probe result and the latest request.
module sprite_mover #(
  parameter int unsigned TILE_LOG2 = 3,
  parameter int unsigned COLS      = 28,
  parameter int unsigned ROWS      = 31,
  parameter int unsigned STEP_DIV  = 8,
  parameter int unsigned START_COL = 13,
  parameter int unsigned START_ROW = 23,
  parameter int unsigned WRAP_ROW  = 14
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          up,
  input  logic                          down,
  input  logic                          left,
  input  logic                          right,
  output logic                          wall_rd,
  output logic [$clog2(COLS*ROWS)-1:0]  wall_addr,
  input  logic                          wall_q,
  output logic [9:0]                    pos_x,
  output logic [9:0]                    pos_y,
  output logic [1:0]                    dir,
  output logic                          moving,
  output logic                          leg_l,
  output logic                          leg_r,
  output logic                          leg_u,
  output logic                          leg_d
);

  localparam int unsigned AddrW = $clog2(COLS * ROWS);
  localparam int unsigned TileW = 10 - TILE_LOG2;
  localparam int unsigned CntW  = $clog2(STEP_DIV);

  localparam logic [CntW-1:0]  StepMax = CntW'(STEP_DIV - 1);
  localparam logic [TileW-1:0] LastCol = TileW'(COLS - 1);
  localparam logic [TileW-1:0] LastRow = TileW'(ROWS - 1);
  localparam logic [TileW-1:0] WrapRow = TileW'(WRAP_ROW);
  localparam logic [9:0]       WrapX   = 10'((COLS - 1) << TILE_LOG2);
  localparam logic [9:0]       StartX  = 10'(START_COL << TILE_LOG2);
  localparam logic [9:0]       StartY  = 10'(START_ROW << TILE_LOG2);

  // Direction encoding doubles as the leg index; opposite direction is bit-0 flip.
  localparam logic [1:0] DirL = 2'd0;
  localparam logic [1:0] DirR = 2'd1;
  localparam logic [1:0] DirU = 2'd2;
  localparam logic [1:0] DirD = 2'd3;

  typedef enum logic [2:0] {
    StIdle, StProbeL, StProbeR, StProbeU, StProbeD, StCapture, StDecide
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [9:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [1:0]        dir_q, dir_d, pend_dir_q, pend_dir_d;
  logic              moving_q, moving_d, pend_v_q, pend_v_d;
  logic [3:0]        open_q, open_d, legs_q, legs_d;
  logic              rd_ok_q;

  logic              step, aligned, take_pend;
  logic [1:0]        mv_dir;
  logic [9:0]        mv_x, mv_y;
  logic [TileW-1:0]  tile_col, tile_row, nb_col, nb_row;
  logic              nb_ok;

  assign step     = (cnt_q == StepMax);
  assign aligned  = (pos_x_q[TILE_LOG2-1:0] == '0) && (pos_y_q[TILE_LOG2-1:0] == '0);
  assign tile_col = pos_x_q[9:TILE_LOG2];
  assign tile_row = pos_y_q[9:TILE_LOG2];

  // Pending request is consumed either by an in-corridor reversal or a turn at DECIDE.
  always_comb begin
    take_pend = 1'b0;
    if (state_q == StIdle) begin
      take_pend = step && !aligned && pend_v_q && (pend_dir_q == (dir_q ^ 2'b01));
    end else if (state_q == StDecide) begin
      take_pend = pend_v_q && open_q[pend_dir_q];
    end
    mv_dir = take_pend ? pend_dir_q : dir_q;
  end

  // One-pixel move in mv_dir, with the tunnel jump on the wrap row.
  always_comb begin
    mv_x = pos_x_q;
    mv_y = pos_y_q;
    unique case (mv_dir)
      DirL:    mv_x = (pos_x_q == '0 && tile_row == WrapRow) ? WrapX : pos_x_q - 10'd1;
      DirR:    mv_x = (tile_col == LastCol && tile_row == WrapRow) ? '0 : pos_x_q + 10'd1;
      DirU:    mv_y = pos_y_q - 10'd1;
      default: mv_y = pos_y_q + 10'd1;
    endcase
  end

  // Neighbour tile for the current probe state; off-map neighbours are never read.
  always_comb begin
    nb_col = tile_col;
    nb_row = tile_row;
    nb_ok  = 1'b0;
    unique case (state_q)
      StProbeL: begin
        if (tile_col != '0) begin
          nb_col = tile_col - TileW'(1);
          nb_ok  = 1'b1;
        end else if (tile_row == WrapRow) begin
          nb_col = LastCol;
          nb_ok  = 1'b1;
        end
      end
      StProbeR: begin
        if (tile_col != LastCol) begin
          nb_col = tile_col + TileW'(1);
          nb_ok  = 1'b1;
        end else if (tile_row == WrapRow) begin
          nb_col = '0;
          nb_ok  = 1'b1;
        end
      end
      StProbeU: begin
        if (tile_row != '0) begin
          nb_row = tile_row - TileW'(1);
          nb_ok  = 1'b1;
        end
      end
      StProbeD: begin
        if (tile_row != LastRow) begin
          nb_row = tile_row + TileW'(1);
          nb_ok  = 1'b1;
        end
      end
      default: ;
    endcase
    wall_rd   = nb_ok;
    wall_addr = AddrW'(32'(nb_row) * COLS + 32'(nb_col));
  end

  // Next-state: step counter, probe sequencing, decision and request capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = step ? '0 : cnt_q + CntW'(1);
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    dir_d      = dir_q;
    moving_d   = moving_q;
    pend_v_d   = pend_v_q;
    pend_dir_d = pend_dir_q;
    open_d     = open_q;
    legs_d     = legs_q;

    unique case (state_q)
      StIdle: begin
        if (step) begin
          if (aligned) begin
            state_d = StProbeL;
          end else if (take_pend || moving_q) begin
            pos_x_d = mv_x;
            pos_y_d = mv_y;
          end
        end
      end
      // wall_q answers the probe issued one cycle earlier.
      StProbeL:  state_d = StProbeR;
      StProbeR: begin
        open_d[DirL] = rd_ok_q & ~wall_q;
        state_d      = StProbeU;
      end
      StProbeU: begin
        open_d[DirR] = rd_ok_q & ~wall_q;
        state_d      = StProbeD;
      end
      StProbeD: begin
        open_d[DirU] = rd_ok_q & ~wall_q;
        state_d      = StCapture;
      end
      StCapture: begin
        open_d[DirD] = rd_ok_q & ~wall_q;
        state_d      = StDecide;
      end
      StDecide: begin
        legs_d  = open_q;
        state_d = StIdle;
        if (take_pend) begin
          moving_d = 1'b1;
          pos_x_d  = mv_x;
          pos_y_d  = mv_y;
        end else if (moving_q && open_q[dir_q]) begin
          pos_x_d = mv_x;
          pos_y_d = mv_y;
        end else begin
          moving_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (take_pend) begin
      dir_d    = pend_dir_q;
      pend_v_d = 1'b0;
    end

    // A fresh request always wins over an older or just-consumed one.
    if (up) begin
      pend_v_d   = 1'b1;
      pend_dir_d = DirU;
    end else if (down) begin
      pend_v_d   = 1'b1;
      pend_dir_d = DirD;
    end else if (left) begin
      pend_v_d   = 1'b1;
      pend_dir_d = DirL;
    end else if (right) begin
      pend_v_d   = 1'b1;
      pend_dir_d = DirR;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pos_x_q    <= StartX;
      pos_y_q    <= StartY;
      dir_q      <= DirL;
      moving_q   <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_dir_q <= DirL;
      open_q     <= '0;
      legs_q     <= '0;
      rd_ok_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      dir_q      <= dir_d;
      moving_q   <= moving_d;
      pend_v_q   <= pend_v_d;
      pend_dir_q <= pend_dir_d;
      open_q     <= open_d;
      legs_q     <= legs_d;
      rd_ok_q    <= nb_ok;
    end
  end

  assign pos_x  = pos_x_q;
  assign pos_y  = pos_y_q;
  assign dir    = dir_q;
  assign moving = moving_q;
  assign leg_l  = legs_q[DirL];
  assign leg_r  = legs_q[DirR];
  assign leg_u  = legs_q[DirU];
  assign leg_d  = legs_q[DirD];

endmodule

// File: doc/sprite_mover.md
SPRITE_MOVER -- requirements
Module: sprite_mover

Interface
REQ-001 Parameter TILE_LOG2, 3: log2 of tile edge in pixels.
REQ-002 Parameter COLS, 28: maze columns.
REQ-003 Parameter ROWS, 31: maze rows.
REQ-004 Parameter STEP_DIV, 8: clk cycles per one-pixel step; values below 8 are illegal.
REQ-005 Parameter START_COL, 13 / START_ROW, 23: reset tile.
REQ-006 Parameter WRAP_ROW, 14: only row with horizontal wrap-around.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 up, down, left, right  in  1 each  direction requests, level-sampled every cycle.
REQ-010 wall_rd  out  1  wall-map read strobe.
REQ-011 wall_addr  out  clog2(COLS*ROWS)  tile index row*COLS+col.
REQ-012 wall_q  in  1  wall bit (1 = wall), valid the cycle after wall_rd.
REQ-013 pos_x, pos_y  out  10 each  sprite top-left pixel.
REQ-014 dir  out  2  heading: 0 L, 1 R, 2 U, 3 D.
REQ-015 moving  out  1  sprite advances on steps.
REQ-016 leg_l, leg_r, leg_u, leg_d  out  1 each  neighbour tile open, as of last probe.

Function
REQ-017 Step counter SHALL count 0..STEP_DIV-1, issuing one step pulse on wrap.
REQ-018 Request priority up>down>left>right; winning request SHALL load pend_dir and set pend_v, replacing any older pending request.
REQ-019 Aligned = low TILE_LOG2 bits of pos_x and pos_y both zero.
REQ-020 Step while not aligned: if pend_v and pend_dir opposite dir, reverse dir, clear pend_v, then move 1 px in dir; else move 1 px in dir if moving; no wall reads.
REQ-021 Step while aligned SHALL start FSM IDLE -> PROBE_L -> PROBE_R -> PROBE_U -> PROBE_D -> CAPTURE -> DECIDE -> IDLE, one cycle per state.
REQ-022 Each PROBE state SHALL assert wall_rd for one cycle with the neighbour address; wall_q is captured into the previous direction's leg in the following state.
REQ-023 Out-of-map neighbour SHALL be a wall with wall_rd low, except on WRAP_ROW where col -1 maps to COLS-1 and col COLS to 0.
REQ-024 DECIDE: leg flags update; if pend_v and leg[pend_dir], dir<=pend_dir, clear pend_v, moving<=1, move 1 px; else if moving and leg[dir], move 1 px; else moving<=0, position held.
REQ-025 Wrap: moving left at pos_x=0 on WRAP_ROW SHALL set pos_x=(COLS-1)<<TILE_LOG2; moving right at col COLS-1 sets pos_x=0.
REQ-026 Step pulses arriving while FSM not IDLE SHALL be ignored (guaranteed absent by REQ-004).
REQ-027 Position arithmetic modulo 2^10; out-of-range start parameters are illegal.

Reset
REQ-028 On rst: pos=(START_COL<<TILE_LOG2, START_ROW<<TILE_LOG2), dir=0, moving=0, pend_v=0, legs=0, wall_rd=0, counter=0, FSM IDLE.
REQ-029 rst mid-probe SHALL abort; wall_rd low the cycle after rst is sampled, no leg update.

Verification (defaults, ROM model: border walls only, 1-cycle latency)
REQ-030 Hold rst 2 cycles -> pos_x=104, pos_y=184, moving=0, legs=0000, wall_rd=0.
REQ-031 right pulse, open corridor -> first DECIDE sets dir=1, moving=1; pos_x +1 per 8 cycles; pos_x=112 after 8 steps; probe addresses 656,658,629,685.
REQ-032 Moving right, down pulse at pos_x=106, tile (14,24) open -> continues right to 112, then dir=3, pos_y=185 next step.
REQ-033 Wall at (15,23), moving right from 104 -> stops at pos_x=112, moving=0, leg_r=0.
REQ-034 Moving right at pos_x=107, left pulse -> next step pos_x=106, dir=0, no wall_rd.
REQ-035 Start pos_x=0 on row 14 moving left -> probe addr 14*28+27=419; next step pos_x=216; rst during PROBE_U -> wall_rd=0 next cycle.
